xsleena_sdr_arbiter: RTL and testbench

Five-client SDRAM read arbiter sitting directly downstream of the XSleena core's memory interface. It merges the main-CPU, sub-CPU, OBJ, BACK1 and BACK2 ROM fetch ports into the single read port of the SDRAM controller. Only one access is outstanding at any time. Video clients take fixed priority, and a wait counter keeps the CPUs from starving.

---
 rtl/xsleena_pkg.sv | 42 ++++
 rtl/xsleena_arb_prio.sv | 35 +++
 rtl/xsleena_sdr_arbiter.sv | 139 +++++++++++++
 tb/tb_xsleena_sdr_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xsleena_pkg.sv
// Shared definitions for the XSleena SDRAM read arbiter.
//   client_t     : client index (OBJ=0, BG1=1, BG2=2, MCPU=3, SCPU=4)
//   arb_state_t  : arbiter FSM states
//   SDR_AW/SDR_DW: SDRAM word address / data widths
//   starve_next  : next value of a CPU starvation counter
package xsleena_pkg;

   localparam int SDR_AW = 25;
   localparam int SDR_DW = 16;
   localparam int NCLI   = 5;

   typedef enum logic [2:0] {
      OBJ  = 3'd0,
      BG1  = 3'd1,
      BG2  = 3'd2,
      MCPU = 3'd3,
      SCPU = 3'd4
   } client_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } arb_state_t;

   // Counter clears when the CPU is granted or stops requesting, counts up
   // (saturating) while it is eligible and kept waiting, and holds while
   // a held request sits in cooldown.
   function automatic logic [7:0] starve_next(input logic [7:0] cnt,
                                              input logic       req,
                                              input logic       elig,
                                              input logic       granted);
      if (!req || granted)
         return '0;
      else if (elig && (cnt != 8'hFF))
         return cnt + 8'd1;
      else
         return cnt;
   endfunction

endpackage

// File: rtl/xsleena_arb_prio.sv
// Combinational winner selection for the SDRAM read arbiter.
//   eligible  in  [NCLI-1:0] per-client eligibility, indexed by client_t
//   starved   in  [1:0]      bit0 = MCPU starved, bit1 = SCPU starved
//   win       out client_t   winning client (OBJ when nothing is eligible)
//   win_valid out 1          at least one client is eligible
module xsleena_arb_prio
   import xsleena_pkg::*;
(
   input  logic [NCLI-1:0] eligible,
   input  logic [1:0]      starved,
   output client_t         win,
   output logic            win_valid
);

   always_comb begin
      win       = OBJ;
      win_valid = |eligible;
      // Starved CPUs jump ahead of the fixed video-first order.
      if (starved[0] && eligible[MCPU])
         win = MCPU;
      else if (starved[1] && eligible[SCPU])
         win = SCPU;
      else if (eligible[OBJ])
         win = OBJ;
      else if (eligible[BG1])
         win = BG1;
      else if (eligible[BG2])
         win = BG2;
      else if (eligible[MCPU])
         win = MCPU;
      else if (eligible[SCPU])
         win = SCPU;
   end

endmodule

// File: rtl/xsleena_sdr_arbiter.sv
// Five-client SDRAM read arbiter (OBJ, BG1, BG2, main CPU, sub CPU) feeding
// the single read port of the SDRAM controller, one access outstanding.
//   CLK, RSTn              clock, synchronous active-low reset
//   <client>_addr/_req     client word address and level request
//   <client>_dout/_rdy     read data (held) and one-cycle ready pulse
//   sdram_addr/_rd         command address and read strobe (held until ack)
//   sdram_ack              controller accepted the command
//   sdram_valid/_dout      one-cycle read data return
module xsleena_sdr_arbiter
   import xsleena_pkg::*;
#(
   parameter logic [7:0] STARVE_LIMIT = 8'd48
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic [SDR_AW-1:0] mcpu_addr,
   input  logic [SDR_AW-1:0] scpu_addr,
   input  logic [SDR_AW-1:0] obj_addr,
   input  logic [SDR_AW-1:0] bg1_addr,
   input  logic [SDR_AW-1:0] bg2_addr,
   input  logic              mcpu_req,
   input  logic              scpu_req,
   input  logic              obj_req,
   input  logic              bg1_req,
   input  logic              bg2_req,
   output logic [SDR_DW-1:0] mcpu_dout,
   output logic [SDR_DW-1:0] scpu_dout,
   output logic [SDR_DW-1:0] obj_dout,
   output logic [SDR_DW-1:0] bg1_dout,
   output logic [SDR_DW-1:0] bg2_dout,
   output logic              mcpu_rdy,
   output logic              scpu_rdy,
   output logic              obj_rdy,
   output logic              bg1_rdy,
   output logic              bg2_rdy,
   output logic [SDR_AW-1:0] sdram_addr,
   output logic              sdram_rd,
   input  logic              sdram_ack,
   input  logic              sdram_valid,
   input  logic [SDR_DW-1:0] sdram_dout
);

   arb_state_t                   state;
   client_t                      gnt;
   client_t                      win;
   logic                         win_valid;
   logic                         grant_now;
   logic [NCLI-1:0]              req;
   logic [NCLI-1:0]              cool;
   logic [NCLI-1:0]              elig;
   logic [NCLI-1:0]              gnt_oh;
   logic [NCLI-1:0]              rdy_r;
   logic [NCLI-1:0][SDR_AW-1:0]  addr_v;
   logic [NCLI-1:0][SDR_DW-1:0]  dout_r;
   logic [7:0]                   mcpu_cnt;
   logic [7:0]                   scpu_cnt;
   logic [1:0]                   starved;

   assign req     = {scpu_req, mcpu_req, bg2_req, bg1_req, obj_req};
   assign addr_v  = {scpu_addr, mcpu_addr, bg2_addr, bg1_addr, obj_addr};
   assign elig    = req & ~cool;
   assign starved = {scpu_cnt >= STARVE_LIMIT, mcpu_cnt >= STARVE_LIMIT};
   assign gnt_oh  = 5'b00001 << gnt;
   assign grant_now = (state == IDLE) && win_valid;

   xsleena_arb_prio u_prio (
      .eligible  (elig),
      .starved   (starved),
      .win       (win),
      .win_valid (win_valid)
   );

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state      <= IDLE;
         gnt        <= OBJ;
         sdram_rd   <= 1'b0;
         sdram_addr <= '0;
         rdy_r      <= '0;
         dout_r     <= '0;
         cool       <= '0;
         mcpu_cnt   <= '0;
         scpu_cnt   <= '0;
      end else begin
         rdy_r    <= '0;
         // Setting in DONE wins over clearing, so a client that dropped req
         // mid-access still gets its cooldown and clears it a cycle later.
         cool     <= (cool & req) | ((state == DONE) ? gnt_oh : '0);
         mcpu_cnt <= starve_next(mcpu_cnt, mcpu_req, elig[MCPU],
                                 grant_now && (win == MCPU));
         scpu_cnt <= starve_next(scpu_cnt, scpu_req, elig[SCPU],
                                 grant_now && (win == SCPU));
         case (state)
            IDLE: begin
               if (win_valid) begin
                  gnt        <= win;
                  sdram_addr <= addr_v[win];
                  sdram_rd   <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (sdram_ack) begin
                  sdram_rd <= 1'b0;
                  if (sdram_valid) begin
                     dout_r[gnt] <= sdram_dout;
                     state       <= DONE;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (sdram_valid) begin
                  dout_r[gnt] <= sdram_dout;
                  state       <= DONE;
               end
            end
            DONE: begin
               rdy_r <= gnt_oh;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign obj_dout  = dout_r[OBJ];
   assign bg1_dout  = dout_r[BG1];
   assign bg2_dout  = dout_r[BG2];
   assign mcpu_dout = dout_r[MCPU];
   assign scpu_dout = dout_r[SCPU];
   assign obj_rdy   = rdy_r[OBJ];
   assign bg1_rdy   = rdy_r[BG1];
   assign bg2_rdy   = rdy_r[BG2];
   assign mcpu_rdy  = rdy_r[MCPU];
   assign scpu_rdy  = rdy_r[SCPU];

endmodule

// File: tb/tb_xsleena_sdr_arbiter.sv
// Self-checking bench for xsleena_sdr_arbiter: table of single-grant
// vectors, a behavioural SDRAM controller, a rdy/dout scoreboard, and
// hand-written sequences for reset, refetch, priority, starvation,
// stray data and reset during an access.
module tb_xsleena_sdr_arbiter;
   import xsleena_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [24:0] a [5];
   logic        obj_req = 0, bg1_req = 0, bg2_req = 0, mcpu_req = 0, scpu_req = 0;
   logic [15:0] obj_dout, bg1_dout, bg2_dout, mcpu_dout, scpu_dout;
   logic        obj_rdy, bg1_rdy, bg2_rdy, mcpu_rdy, scpu_rdy;
   logic [24:0] sdram_addr;
   logic        sdram_rd;
   logic        sdram_ack = 0, sdram_valid = 0;
   logic [15:0] sdram_dout = '0;
   logic [4:0]  rdy_vec;

   typedef struct { client_t c; logic [15:0] d; } exp_t;
   typedef struct { logic [4:0] req; client_t exp; int ack_d; int val_d; } vec_t;

   exp_t        sb [$];
   logic [15:0] exp_last [5];
   vec_t        tbl [8];
   int          tests = 0;
   int          fails = 0;

   // controller model controls
   bit          ctl_en = 1'b1;
   int          ack_dly = 0;
   int          val_dly = 1;
   bit          force_en = 1'b0;
   logic [15:0] force_data = '0;

   always #5 clk = ~clk;

   assign rdy_vec = {scpu_rdy, mcpu_rdy, bg2_rdy, bg1_rdy, obj_rdy};

   xsleena_sdr_arbiter #(.STARVE_LIMIT(8'd8)) dut (
      .CLK(clk), .RSTn(rst_n),
      .mcpu_addr(a[3]), .scpu_addr(a[4]), .obj_addr(a[0]), .bg1_addr(a[1]), .bg2_addr(a[2]),
      .mcpu_req(mcpu_req), .scpu_req(scpu_req), .obj_req(obj_req), .bg1_req(bg1_req), .bg2_req(bg2_req),
      .mcpu_dout(mcpu_dout), .scpu_dout(scpu_dout), .obj_dout(obj_dout), .bg1_dout(bg1_dout), .bg2_dout(bg2_dout),
      .mcpu_rdy(mcpu_rdy), .scpu_rdy(scpu_rdy), .obj_rdy(obj_rdy), .bg1_rdy(bg1_rdy), .bg2_rdy(bg2_rdy),
      .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_ack(sdram_ack),
      .sdram_valid(sdram_valid), .sdram_dout(sdram_dout)
   );

   function automatic logic [15:0] memf(input logic [24:0] ad);
      return ad[15:0] ^ 16'hA5C3;
   endfunction

   function automatic logic [24:0] def_addr(input int i);
      logic [24:0] base;
      base = 25'(i + 1) << 20;
      return base | 25'(16'h0ABC + 16'(i) * 16'h0111);
   endfunction

   function automatic logic [15:0] dout_of(input client_t c);
      case (c)
         OBJ:     return obj_dout;
         BG1:     return bg1_dout;
         BG2:     return bg2_dout;
         MCPU:    return mcpu_dout;
         default: return scpu_dout;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic set_reqs(input logic [4:0] r);
      {scpu_req, mcpu_req, bg2_req, bg1_req, obj_req} = r;
   endtask

   task automatic expect_acc(input client_t c, input logic [15:0] d);
      sb.push_back('{c: c, d: d});
   endtask

   task automatic drain();
      for (int i = 0; i < 80; i++) begin
         if (sb.size() == 0) return;
         @(negedge clk);
      end
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d accesses outstanding, required 0", sb.size());
      sb.delete();
   endtask

   task automatic wait_rd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sdram_rd === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
      tests++;
      fails++;
      $display("FAIL rd_timeout: sdram_rd never rose, required 1");
   endtask

   // Behavioural SDRAM controller: ack after ack_dly cycles, data val_dly
   // cycles after ack (same cycle when val_dly is 0).
   initial begin
      logic [15:0] d;
      forever begin
         @(negedge clk);
         if (ctl_en && rst_n && (sdram_rd === 1'b1)) begin
            d = force_en ? force_data : memf(sdram_addr);
            repeat (ack_dly) @(negedge clk);
            sdram_ack = 1'b1;
            if (val_dly == 0) begin
               sdram_valid = 1'b1;
               sdram_dout  = d;
            end
            @(negedge clk);
            sdram_ack   = 1'b0;
            sdram_valid = 1'b0;
            check("rd_drop_after_ack", 32'(sdram_rd), 32'd0);
            if (val_dly > 0) begin
               repeat (val_dly - 1) @(negedge clk);
               sdram_valid = 1'b1;
               sdram_dout  = d;
               @(negedge clk);
               sdram_valid = 1'b0;
            end
         end
      end
   end

   // Scoreboard side: every rdy pulse must match the oldest expectation.
   initial begin
      exp_t        e;
      logic [15:0] got;
      forever begin
         @(negedge clk);
         if ((|rdy_vec) === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL rdy_unexpected: rdy=%b, required 00000", rdy_vec);
            end else begin
               e   = sb.pop_front();
               got = dout_of(e.c);
               if ((rdy_vec !== (5'b00001 << e.c)) || (got !== e.d)) begin
                  fails++;
                  $display("FAIL rdy_%s: rdy=%b dout=%h, required rdy=%b dout=%h",
                           e.c.name(), rdy_vec, got, 5'b00001 << e.c, e.d);
               end
               exp_last[e.c] = e.d;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int t;
      int gnt_t;
      bit found;
      client_t c;
      logic prev_rd;

      tbl[0] = '{req: 5'b11111, exp: OBJ,  ack_d: 0, val_d: 0};
      tbl[1] = '{req: 5'b11110, exp: BG1,  ack_d: 0, val_d: 1};
      tbl[2] = '{req: 5'b11100, exp: BG2,  ack_d: 1, val_d: 2};
      tbl[3] = '{req: 5'b11000, exp: MCPU, ack_d: 0, val_d: 3};
      tbl[4] = '{req: 5'b10000, exp: SCPU, ack_d: 2, val_d: 0};
      tbl[5] = '{req: 5'b10100, exp: BG2,  ack_d: 1, val_d: 1};
      tbl[6] = '{req: 5'b01010, exp: BG1,  ack_d: 0, val_d: 2};
      tbl[7] = '{req: 5'b01001, exp: OBJ,  ack_d: 3, val_d: 4};

      for (int i = 0; i < 5; i++) begin
         a[i]        = def_addr(i);
         exp_last[i] = '0;
      end

      // Reset with every client requesting.
      rst_n = 1'b0;
      set_reqs(5'b11111);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_rd", 32'(sdram_rd), 32'd0);
         check("reset_rdy", 32'(rdy_vec), 32'd0);
      end
      check("reset_addr", 32'(sdram_addr), 32'd0);
      for (int i = 0; i < 5; i++)
         check("reset_dout", 32'(dout_of(client_t'(i))), 32'd0);
      expect_acc(OBJ, memf(a[OBJ]));
      rst_n = 1'b1;
      @(negedge clk);
      check("first_grant_addr", 32'(sdram_addr), 32'(a[OBJ]));
      set_reqs('0);
      drain();
      @(negedge clk);

      // Table vectors: one cycle of requests, the winner alone is served.
      for (int i = 0; i < 8; i++) begin
         ack_dly = tbl[i].ack_d;
         val_dly = tbl[i].val_d;
         expect_acc(tbl[i].exp, memf(a[tbl[i].exp]));
         set_reqs(tbl[i].req);
         @(negedge clk);
         set_reqs('0);
         drain();
         @(negedge clk);
      end

      // Single BG2 access with slow ack and data; held req must not refetch.
      a[BG2]     = 25'h0123456;
      force_en   = 1'b1;
      force_data = 16'hBEEF;
      ack_dly    = 2;
      val_dly    = 5;
      expect_acc(BG2, 16'hBEEF);
      bg2_req = 1'b1;
      wait_rd(ok);
      if (ok) check("bg2_sdram_addr", 32'(sdram_addr), 32'h0123456);
      drain();
      t = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (sdram_rd === 1'b1) t++;
      end
      check("bg2_no_refetch", 32'(t), 32'd0);
      check("bg2_dout_held", 32'(bg2_dout), 32'hBEEF);
      bg2_req  = 1'b0;
      force_en = 1'b0;
      a[BG2]   = def_addr(2);
      @(negedge clk);

      // Priority: OBJ, BG1, MCPU together, held high throughout.
      ack_dly = 0;
      val_dly = 1;
      expect_acc(OBJ,  memf(a[OBJ]));
      expect_acc(BG1,  memf(a[BG1]));
      expect_acc(MCPU, memf(a[MCPU]));
      set_reqs(5'b01011);
      drain();
      repeat (3) @(negedge clk);
      check("prio_idle_after", 32'(sdram_rd), 32'd0);
      set_reqs('0);
      @(negedge clk);

      // Starvation: video clients re-request right after each rdy,
      // MCPU holds req and must win once its wait count reaches 8.
      ack_dly = 0;
      val_dly = 2;
      obj_req  = 1'b1;
      bg1_req  = 1'b1;
      mcpu_req = 1'b1;
      prev_rd  = 1'b0;
      gnt_t    = -1;
      for (t = 1; t <= 60; t++) begin
         @(negedge clk);
         if ((sdram_rd === 1'b1) && !prev_rd) begin
            found = 1'b0;
            c     = OBJ;
            for (int i = 0; i < 5; i++)
               if (sdram_addr === a[i]) begin
                  found = 1'b1;
                  c     = client_t'(i);
               end
            if (!found) begin
               tests++;
               fails++;
               $display("FAIL starve_addr: sdram_addr=%h matches no client", sdram_addr);
            end else begin
               expect_acc(c, memf(a[c]));
               if (c == MCPU) gnt_t = t;
            end
         end
         prev_rd = sdram_rd;
         if (gnt_t >= 0) break;
         obj_req = (obj_rdy === 1'b1) ? 1'b0 : 1'b1;
         bg1_req = (bg1_rdy === 1'b1) ? 1'b0 : 1'b1;
      end
      check("starve_granted", 32'(gnt_t >= 0), 32'd1);
      check("starve_not_early", 32'(gnt_t >= 9), 32'd1);
      check("starve_in_time", 32'(gnt_t <= 15), 32'd1);
      set_reqs('0);
      drain();
      repeat (2) @(negedge clk);

      // Stray sdram_valid while idle.
      ctl_en = 1'b0;
      sdram_valid = 1'b1;
      sdram_dout  = 16'hDEAD;
      @(negedge clk);
      sdram_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stray_rdy", 32'(rdy_vec), 32'd0);
      end
      for (int i = 0; i < 5; i++)
         check("stray_dout", 32'(dout_of(client_t'(i))), 32'(exp_last[i]));

      // Reset while in WAIT, late data ignored, then a normal access.
      bg1_req = 1'b1;
      wait_rd(ok);
      bg1_req   = 1'b0;
      sdram_ack = 1'b1;
      @(negedge clk);
      sdram_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_rd", 32'(sdram_rd), 32'd0);
      check("midrst_rdy", 32'(rdy_vec), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) exp_last[i] = '0;
      sdram_valid = 1'b1;
      sdram_dout  = 16'h1111;
      @(negedge clk);
      sdram_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("late_valid_rdy", 32'(rdy_vec), 32'd0);
      end
      check("late_valid_dout", 32'(bg1_dout), 32'd0);
      ctl_en  = 1'b1;
      ack_dly = 1;
      val_dly = 2;
      expect_acc(MCPU, memf(a[MCPU]));
      mcpu_req = 1'b1;
      @(negedge clk);
      mcpu_req = 1'b0;
      drain();
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
